// File: rtl/mvm_pkg.sv
// Shared definitions for mat_vec_mult, its result drain and their benches.
package mvm_pkg;

  localparam int MVM_ROWS = 8;
  localparam int MVM_DW   = 8;
  localparam int MVM_ACCW = 24;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEND,
    CLEAR,
    WAIT_LOW
  } drain_state_t;

endpackage

// File: rtl/mvm_result_drain.sv
// Result drain for mat_vec_mult.
// Waits for a rising edge on done and snapshots all row results.
// Streams the rows in order 0..NUM_ROWS-1 over valid/ready.
// Pulses clr once so the multiplier starts the next pass clean.
// Then waits for done to fall, so a stuck-high done cannot start a second pass.
module mvm_result_drain
  import mvm_pkg::*;
#(
  parameter  int DATA_WIDTH = MVM_DW,
  parameter  int NUM_ROWS   = MVM_ROWS,
  parameter  int ACC_WIDTH  = 3 * DATA_WIDTH,
  localparam int IDX_W      = $clog2(NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 done,
  input  logic [ACC_WIDTH-1:0] res_in [NUM_ROWS],
  output logic                 clr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic [IDX_W-1:0]     m_idx,
  output logic                 m_last,
  output logic                 busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

  drain_state_t         r_state;
  drain_state_t         w_stateNext;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idxNext;
  logic                 r_doneQ;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_clr;
  logic                 r_busy;
  logic [ACC_WIDTH-1:0] r_data;
  logic [ACC_WIDTH-1:0] w_dataNext;
  logic [ACC_WIDTH-1:0] r_shadow [NUM_ROWS];
  logic                 w_xfer;

  assign w_xfer  = r_valid && m_ready;
  assign clr     = r_clr;
  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_idx   = r_idx;
  assign m_last  = r_last;
  assign busy    = r_busy;

  // Next-state and next-index logic.
  // During CAPTURE the first element comes straight from res_in, because the shadow bank
  // is loaded on the same edge.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    case (r_state)
      IDLE: begin
        if (!r_doneQ && done) w_stateNext = CAPTURE;
      end
      CAPTURE: begin
        w_stateNext = SEND;
        w_idxNext   = '0;
      end
      SEND: begin
        if (w_xfer) begin
          w_idxNext = r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) w_stateNext = CLEAR;
        end
      end
      CLEAR: begin
        w_stateNext = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!done) w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
    w_dataNext = (r_state == CAPTURE) ? res_in[w_idxNext] : r_shadow[w_idxNext];
  end

  // State, index and all outputs are registered.
  // Each output is decoded from the next state, so it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_doneQ <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_doneQ <= done;
      r_valid <= (w_stateNext == SEND);
      r_last  <= (w_stateNext == SEND) && (w_idxNext == LAST_IDX);
      r_clr   <= (w_stateNext == CLEAR);
      r_busy  <= (w_stateNext != IDLE);
      if (w_stateNext == SEND) r_data <= w_dataNext;
    end
  end

  // Snapshot of every row, taken once per pass.
  // Later changes on res_in cannot disturb the stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) r_shadow[i] <= '0;
    end else if (r_state == CAPTURE) begin
      for (int i = 0; i < NUM_ROWS; i++) r_shadow[i] <= res_in[i];
    end
  end

endmodule

// File: tb/tb_mvm_result_drain.sv
// Directed self-checking bench for mvm_result_drain.
module tb_mvm_result_drain;

  logic        clk;
  logic        rst_n;
  logic        done;
  logic [23:0] res_in [8];
  logic        clr;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic [2:0]  m_idx;
  logic        m_last;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [23:0] basicExp [8];
  logic [23:0] realExp  [8];
  int          aRow [8] = '{10, 10, 0, 0, 16, 16, 16, 16};
  int          bVec [8] = '{2, 2, 5, 3, 3, 3, 3, 3};
  int          span;
  int          clrCount;
  int          validCount;

  mvm_result_drain dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .done    (done),
    .res_in  (res_in),
    .clr     (clr),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .busy    (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden dot product of row r.
  // Every entry of A row r equals aRow[r].
  function automatic logic [23:0] rowDot(input int r);
    int acc;
    acc = 0;
    for (int c = 0; c < 8; c++) acc += aRow[r] * bVec[c];
    return 24'(acc);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rstN, input logic doneV, input logic readyV);
    rst_n   = rstN;
    done    = doneV;
    m_ready = readyV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Consume up to maxBeats beats, driving m_ready from the pattern.
  // Pattern mode 0 holds m_ready at 1.
  // Pattern mode 1 repeats 1,0,0.
  // Every cycle with m_valid high is checked against the expected beat, which also
  // proves the data is held steady while m_ready is low.
  task automatic drainPass(input string tag, input int mode, input int maxBeats,
                           input logic [23:0] exp [8], output int spanOut);
    int   beat;
    int   cyc;
    int   firstCyc;
    int   lastCyc;
    logic rdy;
    beat     = 0;
    cyc      = 0;
    firstCyc = -1;
    lastCyc  = -1;
    while (beat < maxBeats && cyc < 200) begin
      rdy     = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      m_ready = rdy;
      if (firstCyc >= 0) checkOutput({tag, "_valid_held"}, 32'(m_valid), 32'd1);
      if (m_valid) begin
        if (firstCyc < 0) firstCyc = cyc;
        checkOutput({tag, "_idx"},  32'(m_idx),  32'(beat));
        checkOutput({tag, "_data"}, 32'(m_data), 32'(exp[beat]));
        checkOutput({tag, "_last"}, 32'(m_last), 32'(beat == 7));
        if (rdy) begin
          beat++;
          lastCyc = cyc;
        end
      end
      tick();
      cyc++;
    end
    if (beat < maxBeats) checkOutput({tag, "_timeout_beats"}, 32'(beat), 32'(maxBeats));
    m_ready = 1'b0;
    spanOut = lastCyc - firstCyc + 1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      basicExp[i] = 24'(100 * i + 1);
      realExp[i]  = rowDot(i);
      res_in[i]   = basicExp[i];
    end

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_clr",   32'(clr),     32'd0);
    checkOutput("rst_busy",  32'(busy),    32'd0);
    checkOutput("rst_last",  32'(m_last),  32'd0);
    checkOutput("rst_data",  32'(m_data),  32'd0);
    checkOutput("rst_idx",   32'(m_idx),   32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Basic pass, with the latency check and a continuous m_ready.
    done = 1'b1;
    tick();
    checkOutput("basic_cap_busy",  32'(busy),    32'd1);
    checkOutput("basic_cap_valid", 32'(m_valid), 32'd0);
    tick();
    checkOutput("basic_first_valid", 32'(m_valid), 32'd1);
    drainPass("basic", 0, 8, basicExp, span);
    checkOutput("basic_span", 32'(span), 32'd8);
    checkOutput("basic_clr_on",    32'(clr),     32'd1);
    checkOutput("basic_clr_valid", 32'(m_valid), 32'd0);
    tick();
    checkOutput("basic_clr_off",  32'(clr),  32'd0);
    checkOutput("basic_wait_busy", 32'(busy), 32'd1);
    done = 1'b0;
    tick();
    checkOutput("basic_idle_busy", 32'(busy), 32'd0);

    // Backpressure with the 1,0,0 m_ready pattern.
    done = 1'b1;
    tick();
    tick();
    drainPass("bp", 1, 8, basicExp, span);
    checkOutput("bp_clr_on", 32'(clr), 32'd1);
    done = 1'b0;
    tick();
    tick();
    checkOutput("bp_idle_busy", 32'(busy), 32'd0);

    // Capture isolation: res_in is overwritten right after capture.
    done = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) res_in[i] = 24'hFFFFFF;
    drainPass("iso", 0, 8, basicExp, span);
    done = 1'b0;
    tick();
    tick();

    // Stuck done: a single pass and a single clr, then a new pass after done falls.
    for (int i = 0; i < 8; i++) res_in[i] = basicExp[i];
    done = 1'b1;
    tick();
    tick();
    drainPass("stuck1", 0, 8, basicExp, span);
    checkOutput("stuck_clr_on", 32'(clr), 32'd1);
    clrCount   = 0;
    validCount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clr) clrCount++;
      if (m_valid) validCount++;
    end
    checkOutput("stuck_extra_clr",   32'(clrCount),   32'd0);
    checkOutput("stuck_extra_valid", 32'(validCount), 32'd0);
    checkOutput("stuck_busy",        32'(busy),       32'd1);
    done = 1'b0;
    tick();
    checkOutput("stuck_release_busy", 32'(busy), 32'd0);
    done = 1'b1;
    tick();
    checkOutput("stuck_rearm_busy", 32'(busy), 32'd1);
    tick();
    drainPass("stuck2", 0, 8, basicExp, span);
    done = 1'b0;
    tick();
    tick();

    // Reset in the middle of SEND after three beats.
    done = 1'b1;
    tick();
    tick();
    drainPass("mid", 0, 3, basicExp, span);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_busy",  32'(busy),    32'd0);
    checkOutput("mid_rst_idx",   32'(m_idx),   32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    clrCount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (clr || busy) clrCount++;
    end
    checkOutput("mid_quiet", 32'(clrCount), 32'd0);
    done = 1'b1;
    tick();
    tick();
    drainPass("mid_restart", 0, 8, basicExp, span);
    done = 1'b0;
    tick();
    tick();

    // Real multiplier data, with done already high when reset is released.
    for (int i = 0; i < 8; i++) res_in[i] = realExp[i];
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("real_rise_from_reset", 32'(busy), 32'd1);
    tick();
    checkOutput("real_row0", 32'(m_data), 32'd240);
    drainPass("real", 1, 8, realExp, span);
    checkOutput("real_clr_on", 32'(clr), 32'd1);
    done = 1'b0;
    tick();
    tick();
    checkOutput("real_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
